serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer that drives the team's one-bit full-adder cell. It latches two WIDTH-bit operands and a carry-in, then presents one bit pair per cycle, LSB first, to the cell's A/B/Cin inputs. Each cycle it captures the cell's Sum/Cout, recirculates the carry, and assembles the WIDTH-bit result plus carry-out. It sits directly upstream of the full-adder cell, feeding it, and downstream of it, consuming its outputs.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helper for the bit-serial adder sequencer.
// The state encoding is fixed so that it stays stable across every block that imports it.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width. Legal widths start at 2.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external one-bit full-adder cell LSB first
// and assembles its Sum/Cout into a WIDTH-bit result plus carry-out.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_run     = (r_state == RUN);
    assign w_last    = (r_cnt == LAST);
    assign w_res_nxt = {fa_sum, r_res_sh[WIDTH-1:1]};

    // Cell inputs come only from registers, so there is no loop through the cell.
    assign fa_a     = w_run & r_a_sh[0];
    assign fa_b     = w_run & r_b_sh[0];
    assign fa_cin   = w_run & r_carry;

    assign busy     = w_run;
    assign done     = (r_state == DONE);
    assign sum_out  = r_sum;
    assign cout_out = r_cout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= b_in;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_res_sh <= w_res_nxt;
                    r_carry  <= fa_cout;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_res_nxt;
                        r_cout <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=16,
// each driving a behavioural full-adder cell.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8, busy8, done8, cout8;
    logic [7:0] a_in8, b_in8, sum8;

    logic        start16, cin16, fa_a16, fa_b16, fa_cin16, fa_sum16, fa_cout16, busy16, done16, cout16;
    logic [15:0] a_in16, b_in16, sum16;

    assign fa_sum8   = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_cout8  = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
    assign fa_sum16  = fa_a16 ^ fa_b16 ^ fa_cin16;
    assign fa_cout16 = (fa_a16 & fa_b16) | (fa_a16 & fa_cin16) | (fa_b16 & fa_cin16);

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a_in8), .b_in(b_in8), .cin(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a_in(a_in16), .b_in(b_in16), .cin(cin16),
        .fa_a(fa_a16), .fa_b(fa_b16), .fa_cin(fa_cin16), .fa_sum(fa_sum16), .fa_cout(fa_cout16),
        .busy(busy16), .done(done16), .sum_out(sum16), .cout_out(cout16)
    );

    int checks = 0;
    int errors = 0;
    int n_done8 = 0;
    int n_done16 = 0;

    always @(posedge clk) begin
        if (done8)  n_done8  <= n_done8 + 1;
        if (done16) n_done16 <= n_done16 + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic [7:0] exp_ctrace;
    } vec_t;

    // One WIDTH=8 addition; operands are scrambled right after acceptance.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] ctr, output bit lat_ok, output bit idle_zero);
        @(negedge clk);
        a_in8 = a; b_in8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0; a_in8 = ~a; b_in8 = ~b; cin8 = ~c;
        lat_ok = 1'b1; idle_zero = 1'b1; ctr = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!busy8 || done8) lat_ok = 1'b0;
            ctr[k] = fa_cin8;
        end
        @(negedge clk);
        if (busy8 || !done8) lat_ok = 1'b0;
        if (fa_a8 | fa_b8 | fa_cin8) idle_zero = 1'b0;
        @(negedge clk);
        if (busy8 || done8) lat_ok = 1'b0;
        if (fa_a8 | fa_b8 | fa_cin8) idle_zero = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output bit timed_out);
        @(negedge clk);
        a_in16 = a; b_in16 = b; cin16 = c; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0; a_in16 = $urandom(); b_in16 = $urandom();
        timed_out = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done16) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0]  ctr;
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        logic        rc;
        logic [8:0]  exp9;
        logic [16:0] exp17;
        bit          lat_ok, idle_zero, to;
        int          dcnt, starts8, starts16;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 8'hF0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFE};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF};
        vecs[3] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 8'h03};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 8'hFF};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 8'h00};

        rst = 1'b1;
        start8 = 0; a_in8 = 0; b_in8 = 0; cin8 = 0;
        start16 = 0; a_in16 = 0; b_in16 = 0; cin16 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_sum", sum8, 0);
        chk("reset_cout", cout8, 0);
        chk("reset_fa", {fa_a8, fa_b8, fa_cin8}, 0);

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].c, ctr, lat_ok, idle_zero);
            chk($sformatf("vec%0d_latency", i), lat_ok, 1);
            chk($sformatf("vec%0d_idle_fa", i), idle_zero, 1);
            chk($sformatf("vec%0d_sum", i), sum8, vecs[i].exp_sum);
            chk($sformatf("vec%0d_cout", i), cout8, vecs[i].exp_cout);
            chk($sformatf("vec%0d_cin_trace", i), ctr, vecs[i].exp_ctrace);
        end

        // start pulses in RUN cycle 3 and in the DONE cycle must be dropped
        @(negedge clk);
        a_in8 = 8'h3C; b_in8 = 8'h5A; cin8 = 0; start8 = 1;
        @(posedge clk);
        #1 start8 = 0;
        dcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done8) dcnt++;
            if (c == 3 || c == 9) begin
                a_in8 = 8'h11; b_in8 = 8'h22; cin8 = 1; start8 = 1;
            end else begin
                start8 = 0;
            end
        end
        start8 = 0;
        chk("drop_done_count", dcnt, 1);
        chk("drop_sum", sum8, 8'h96);
        chk("drop_cout", cout8, 0);
        chk("drop_busy_after", busy8, 0);

        // reset in RUN cycle 4 aborts and clears the result
        @(negedge clk);
        a_in8 = 8'hFF; b_in8 = 8'h01; cin8 = 0; start8 = 1;
        @(posedge clk);
        #1 start8 = 0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_cout", cout8, 0);
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        run8(8'h01, 8'h01, 1'b1, ctr, lat_ok, idle_zero);
        chk("post_abort_sum", sum8, 8'h03);
        chk("post_abort_cout", cout8, 0);
        chk("post_abort_latency", lat_ok, 1);

        // rst and start together: reset wins
        @(negedge clk);
        rst = 1; start8 = 1; a_in8 = 8'h12; b_in8 = 8'h34;
        @(posedge clk);
        #1 rst = 0; start8 = 0;
        @(negedge clk);
        chk("rst_start_busy", busy8, 0);
        chk("rst_start_sum", sum8, 0);

        starts8 = n_done8;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom()); rb = 8'($urandom()); rc = 1'($urandom());
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run8(ra, rb, rc, ctr, lat_ok, idle_zero);
            starts8++;
            if ({cout8, sum8} !== exp9 || !lat_ok || !idle_zero)
                chk($sformatf("rand8_%0d", i), {lat_ok, idle_zero, cout8, sum8}, {2'b11, exp9});
            else
                checks++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        chk("rand8_done_count", n_done8, starts8);

        starts16 = n_done16;
        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom()); rb16 = 16'($urandom()); rc = 1'($urandom());
            cin16 = rc;
            exp17 = {1'b0, ra16} + {1'b0, rb16} + {16'd0, rc};
            run16(ra16, rb16, rc, to);
            starts16++;
            chk($sformatf("rand16_%0d", i), {to, cout16, sum16}, {1'b0, exp17});
            if (to) break;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        @(negedge clk);
        chk("rand16_done_count", n_done16, starts16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
